// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: byte width, RX FIFO geometry and status-register bit
// positions used by the bus-side register decode.
package uart_rx_fifo_pkg;

  localparam int BYTE_W        = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AW    = 4;

  localparam int STAT_TX_BUSY  = 0;
  localparam int STAT_RX_AVAIL = 1;
  localparam int STAT_OVERRUN  = 2;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// RX byte FIFO between the UART receiver and the bus register read path.
// First-word-fall-through: rd_data shows the oldest byte while empty=0.
// Ports:
//   clk, rst                 clock, async active-high reset
//   wr_data, wr_valid        push from the receiver data-ready pulse
//   rd_en                    pop from the RX data register read-start
//   rd_data                  oldest byte, 0 when empty
//   empty, full, count       fill status
//   overrun, clr_overrun     sticky dropped-push flag and its clear
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW    = RX_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clr_overrun
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  byte_t          mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;
  logic           drop;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign count = cnt;

  // A pop in the same cycle frees the slot, so a push into a full
  // FIFO is still accepted when a pop accompanies it.
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_valid & (~full | do_pop);
  assign drop    = wr_valid & ~do_push;

  assign rd_data = empty ? 8'h00 : mem[rp];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        wp <= wp + 1'b1;
      end
      if (do_pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Expected values are hand-derived or from a small queue model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic q, input logic [7:0] b,
                     input logic c);
    wr_valid = p;
    rd_en = q;
    wr_data = b;
    clr_overrun = c;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_en = 1'b0;
    clr_overrun = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] nb;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd", 32'(rd_data), 0);
    chk("rst_ovr", 32'(overrun), 0);
    rst = 1'b0;

    cyc(1, 0, 8'hA5, 0);
    chk("a5_empty", 32'(empty), 0);
    chk("a5_count", 32'(count), 1);
    chk("a5_rd", 32'(rd_data), 32'hA5);
    cyc(0, 1, 8'h00, 0);
    chk("a5_pop_empty", 32'(empty), 1);
    chk("a5_pop_rd", 32'(rd_data), 0);

    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    cyc(1, 0, 8'hFF, 0);
    chk("drop_count", 32'(count), 16);
    chk("drop_ovr", 32'(overrun), 1);
    cyc(1, 0, 8'hFF, 1);
    chk("drop_clr_ovr", 32'(overrun), 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_seq", 32'(rd_data), 32'(i));
      cyc(0, 1, 8'h00, 0);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovr_held", 32'(overrun), 1);
    cyc(0, 0, 8'h00, 1);
    chk("clr_ovr", 32'(overrun), 0);

    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h10 + i), 0);
    cyc(1, 1, 8'h55, 0);
    chk("fullpp_count", 32'(count), 16);
    chk("fullpp_ovr", 32'(overrun), 0);
    for (int i = 1; i < 16; i++) begin
      chk("fullpp_seq", 32'(rd_data), 32'(8'h10 + i));
      cyc(0, 1, 8'h00, 0);
    end
    chk("fullpp_last", 32'(rd_data), 32'h55);
    cyc(0, 1, 8'h00, 0);
    chk("fullpp_empty", 32'(empty), 1);

    cyc(1, 1, 8'h3C, 0);
    chk("emptypp_count", 32'(count), 1);
    chk("emptypp_rd", 32'(rd_data), 32'h3C);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    chk("popempty_count", 32'(count), 0);
    chk("popempty_empty", 32'(empty), 1);
    chk("popempty_ovr", 32'(overrun), 0);

    q.delete();
    for (int i = 0; i < 2; i++) begin
      nb = 8'(8'hC0 + i);
      cyc(1, 0, nb, 0);
      q.push_back(nb);
    end
    for (int i = 0; i < 40; i++) begin
      nb = 8'(i * 7 + 3);
      case (i % 3)
        0: begin
          cyc(1, 0, nb, 0);
          q.push_back(nb);
        end
        1: begin
          chk("wrap_rd", 32'(rd_data), 32'(q[0]));
          cyc(0, 1, 8'h00, 0);
          void'(q.pop_front());
        end
        default: begin
          chk("wrap_rd", 32'(rd_data), 32'(q[0]));
          cyc(1, 1, nb, 0);
          void'(q.pop_front());
          q.push_back(nb);
        end
      endcase
      chk("wrap_count", 32'(count), 32'(q.size()));
    end
    while (q.size() > 0) begin
      chk("wrap_drain", 32'(rd_data), 32'(q[0]));
      cyc(0, 1, 8'h00, 0);
      void'(q.pop_front());
    end
    chk("wrap_empty", 32'(empty), 1);

    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h80 + i), 0);
    cyc(1, 0, 8'hEE, 0);
    for (int i = 0; i < 11; i++) cyc(0, 1, 8'h00, 0);
    chk("pre_rst_count", 32'(count), 5);
    chk("pre_rst_ovr", 32'(overrun), 1);
    chk("pre_rst_rd", 32'(rd_data), 32'h8B);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_ovr", 32'(overrun), 0);
    chk("arst_rd", 32'(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 8'h7E, 0);
    chk("post_rst_rd", 32'(rd_data), 32'h7E);
    chk("post_rst_count", 32'(count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
